// File: rtl/multadd_driver_if.sv
// Bundle of the host byte bus, the operand/result path to the multiply-add
// unit and the result handshake. Clock and reset stay plain ports.
// The slave modport is the driver; the master modport is the host plus the
// multiply-add unit.
interface multadd_driver_if #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 17
);
    logic              iVALID;
    logic              oREADY;
    logic [DATA_W-1:0] iDATA;
    logic              iMODE;
    logic [DATA_W-1:0] oA0;
    logic [DATA_W-1:0] oB0;
    logic [DATA_W-1:0] oA1;
    logic [DATA_W-1:0] oB1;
    logic              oSEL;
    logic [RES_W-1:0]  iRESULT;
    logic              oRES_VALID;
    logic              iRES_READY;
    logic [RES_W-1:0]  oRES_DATA;
    logic              oBUSY;

    modport slave (
        input  iVALID, iDATA, iMODE, iRESULT, iRES_READY,
        output oREADY, oA0, oB0, oA1, oB1, oSEL, oRES_VALID, oRES_DATA, oBUSY
    );

    modport master (
        output iVALID, iDATA, iMODE, iRESULT, iRES_READY,
        input  oREADY, oA0, oB0, oA1, oB1, oSEL, oRES_VALID, oRES_DATA, oBUSY
    );
endinterface

// File: rtl/multadd_driver.sv
// Transaction front-end for the 8-bit dual multiply-add unit.
// Collects A0, B0, A1, B1 (mode sampled with A0), presents them stable to the
// unit, waits its fixed latency, captures the result and hands it back.
// Optional feature: define MULTADD_DRV_CHECK_EN to add a local reference model
// and a sticky oMISMATCH output.
module multadd_driver #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 17,
    parameter int LATENCY = 6
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    multadd_driver_if.slave   bus
`ifdef MULTADD_DRV_CHECK_EN
    ,
    output logic              oMISMATCH
`endif
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    typedef logic [3:0][DATA_W-1:0] ops_t;

    state_e             state_q,     state_d;
    logic [1:0]         byte_cnt_q,  byte_cnt_d;
    ops_t               stage_q,     stage_d;
    logic               mode_q,      mode_d;
    ops_t               ops_q,       ops_d;
    logic               sel_q,       sel_d;
    logic [CNT_W-1:0]   wait_q,      wait_d;
    logic [RES_W-1:0]   res_data_q,  res_data_d;
    logic               res_valid_q, res_valid_d;

    // Capture happens in the last WAIT cycle.
    logic capture;
    assign capture = (state_q == S_WAIT) && (wait_q == '0);

    // Next-state, byte staging, operand issue, wait count and result capture.
    always_comb begin
        // NOTE: every target gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        stage_d     = stage_q;
        mode_d      = mode_q;
        ops_d       = ops_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;

        unique case (state_q)
            S_LOAD: begin
                if (bus.iVALID) begin
                    stage_d[byte_cnt_q] = bus.iDATA;
                    if (byte_cnt_q == 2'd0) begin
                        mode_d = bus.iMODE;
                    end
                    // Wraps 3 -> 0, ready for the next transaction.
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                ops_d   = stage_q;
                sel_d   = mode_q;
                wait_d  = CNT_W'(LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (capture) begin
                    res_data_d  = bus.iRESULT;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (bus.iRES_READY) begin
                    res_valid_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and datapath registers; everything clears on reset so a partial
    // transaction is discarded.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_LOAD;
            byte_cnt_q  <= '0;
            stage_q     <= '0;
            mode_q      <= 1'b0;
            ops_q       <= '0;
            sel_q       <= 1'b0;
            wait_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge
            // values of the others, independent of statement order.
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            stage_q     <= stage_d;
            mode_q      <= mode_d;
            ops_q       <= ops_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.oREADY     = (state_q == S_LOAD);
    assign bus.oBUSY      = (state_q != S_LOAD);
    assign bus.oA0        = ops_q[0];
    assign bus.oB0        = ops_q[1];
    assign bus.oA1        = ops_q[2];
    assign bus.oB1        = ops_q[3];
    assign bus.oSEL       = sel_q;
    assign bus.oRES_VALID = res_valid_q;
    assign bus.oRES_DATA  = res_data_q;

`ifdef MULTADD_DRV_CHECK_EN
    // Same arithmetic as the multiply-add unit, truncated to RES_W.
    function automatic logic [RES_W-1:0] madd_ref(input ops_t op, input logic sel);
        logic [2*DATA_W-1:0] p0;
        logic [2*DATA_W-1:0] p1;
        logic [4*DATA_W-1:0] acc;
        p0  = {{DATA_W{1'b0}}, op[0]} * {{DATA_W{1'b0}}, op[1]};
        p1  = {{DATA_W{1'b0}}, op[2]} * {{DATA_W{1'b0}}, op[3]};
        acc = {{2*DATA_W{1'b0}}, p0} + {{2*DATA_W{1'b0}}, p1};
        if (!sel) begin
            acc = acc + ({{2*DATA_W{1'b0}}, p0} * {{2*DATA_W{1'b0}}, p1});
        end
        return acc[RES_W-1:0];
    endfunction

    logic [RES_W-1:0] expected_q, expected_d;
    logic             mismatch_q, mismatch_d;

    // Expected value latched at ISSUE; mismatch flag is sticky until reset.
    always_comb begin
        expected_d = expected_q;
        mismatch_d = mismatch_q;
        if (state_q == S_ISSUE) begin
            expected_d = madd_ref(stage_q, mode_q);
        end
        if (capture && (bus.iRESULT != expected_q)) begin
            mismatch_d = 1'b1;
        end
    end

    // Reference-model registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            expected_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign oMISMATCH = mismatch_q;
`endif
endmodule

// File: tb/tb_multadd_driver.sv
// Self-checking bench for multadd_driver: fixed vectors with known results,
// hand-written flow-control / reset / throughput sequences, and randomized
// transactions checked against a plain-arithmetic model.
module tb_multadd_driver;
    localparam int DATA_W = 8;
    localparam int RES_W  = 17;
    localparam int LAT    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    multadd_driver_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

`ifdef MULTADD_DRV_CHECK_EN
    logic mismatch;
    multadd_driver #(.DATA_W(DATA_W), .RES_W(RES_W), .LATENCY(LAT)) dut (
        .iCLK(clk), .iRST_N(rst_n), .bus(bus.slave), .oMISMATCH(mismatch)
    );
`else
    multadd_driver #(.DATA_W(DATA_W), .RES_W(RES_W), .LATENCY(LAT)) dut (
        .iCLK(clk), .iRST_N(rst_n), .bus(bus.slave)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result of the multiply-add unit from the specification's arithmetic.
    function automatic logic [RES_W-1:0] madd(input int a0, input int b0,
                                              input int a1, input int b1, input bit sel);
        longint p0, p1, r;
        p0 = longint'(a0) * longint'(b0);
        p1 = longint'(a1) * longint'(b1);
        r  = sel ? (p0 + p1) : (p0 + p1 + p0 * p1);
        return RES_W'(r % 131072);
    endfunction

    // Multiply-add unit model: result valid LAT cycles after the operands
    // become stable (first stage combinational, LAT-1 register stages).
    logic [RES_W-1:0] pipe [0:LAT-2];
    logic [RES_W-1:0] inject = '0;
    always @(posedge clk) begin
        pipe[0] <= madd(int'(bus.oA0), int'(bus.oB0), int'(bus.oA1), int'(bus.oB1), bus.oSEL);
        for (int i = 1; i <= LAT - 2; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.iRESULT = pipe[LAT-2] + inject;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; optional stall in HOLD with ignored iVALID pulses.
    task automatic run_txn(input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input bit mode, input logic [RES_W-1:0] exp,
                           input int hold_cycles, input bit pulse);
        logic [7:0] bytes [4];
        int t;
        int k;
        bytes[0] = a0; bytes[1] = b0; bytes[2] = a1; bytes[3] = b1;
        for (int b = 0; b < 4; b++) begin
            bus.iVALID = 1'b1;
            bus.iDATA  = bytes[b];
            // Mode only matters with byte 0; drive the opposite value otherwise.
            bus.iMODE  = (b == 0) ? mode : ~mode;
            t = 0;
            while (!bus.oREADY && t < 50) begin
                step();
                t++;
            end
            if (t == 50) begin
                check("ready_timeout", 0, 1);
                bus.iVALID = 1'b0;
                return;
            end
            step();
        end
        bus.iVALID = 1'b0;
        // Cycle N+1 (ISSUE): busy, not ready.
        check("issue_busy", bus.oBUSY, 1);
        check("issue_ready", bus.oREADY, 0);
        step();
        check("op_a0", bus.oA0, a0);
        check("op_b0", bus.oB0, b0);
        check("op_a1", bus.oA1, a1);
        check("op_b1", bus.oB1, b1);
        check("op_sel", bus.oSEL, mode);
        k = 1;
        while (!bus.oRES_VALID && k < 100) begin
            step();
            k++;
        end
        check("res_latency", k, LAT + 1);
        check("res_data", bus.oRES_DATA, exp);
        for (int i = 0; i < hold_cycles; i++) begin
            bus.iRES_READY = 1'b0;
            bus.iVALID     = pulse ? i[0] : 1'b0;
            bus.iDATA      = 8'($urandom);
            step();
            check("hold_valid", bus.oRES_VALID, 1);
            check("hold_data", bus.oRES_DATA, exp);
            check("hold_ready", bus.oREADY, 0);
            check("hold_a0", bus.oA0, a0);
        end
        bus.iVALID     = 1'b0;
        bus.iRES_READY = 1'b1;
        step();
        bus.iRES_READY = 1'b0;
        check("post_valid", bus.oRES_VALID, 0);
        check("post_ready", bus.oREADY, 1);
    endtask

    typedef struct {
        logic [7:0]       a0, b0, a1, b1;
        bit               mode;
        logic [RES_W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c0, c1;
        vecs[0] = '{8'd3,   8'd4,   8'd5,   8'd6,   1'b1, 17'd42};
        vecs[1] = '{8'd3,   8'd4,   8'd5,   8'd6,   1'b0, 17'd402};
        vecs[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 17'd130050};
        vecs[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 17'd129027};
        vecs[4] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 17'd0};
        vecs[5] = '{8'd1,   8'd2,   8'd3,   8'd4,   1'b1, 17'd14};

        bus.iVALID = 1'b0; bus.iDATA = '0; bus.iMODE = 1'b0; bus.iRES_READY = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_ready", bus.oREADY, 1);
        check("rst_busy", bus.oBUSY, 0);
        check("rst_res_valid", bus.oRES_VALID, 0);
        check("rst_res_data", bus.oRES_DATA, 0);
        check("rst_a0", bus.oA0, 0);
        check("rst_b1", bus.oB1, 0);
        check("rst_sel", bus.oSEL, 0);
`ifdef MULTADD_DRV_CHECK_EN
        check("rst_mismatch", mismatch, 0);
`endif

        // Table vectors.
        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].mode, vecs[i].exp, 0, 1'b0);

        // Stall in HOLD for 10 cycles with iVALID pulses, then a clean follow-up.
        run_txn(8'd7, 8'd8, 8'd9, 8'd10, 1'b1, 17'd146, 10, 1'b1);
        run_txn(8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 17'd42, 0, 1'b0);

        // Reset after two bytes; the partial transaction must vanish.
        bus.iVALID = 1'b1; bus.iMODE = 1'b0; bus.iDATA = 8'd200;
        step();
        bus.iDATA = 8'd201;
        step();
        bus.iVALID = 1'b0;
        rst_n = 1'b0;
        #3;
        check("mid_rst_res_data", bus.oRES_DATA, 0);
        check("mid_rst_a0", bus.oA0, 0);
        check("mid_rst_sel", bus.oSEL, 0);
        check("mid_rst_ready", bus.oREADY, 1);
        rst_n = 1'b1;
        step();
        run_txn(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 17'd14, 0, 1'b0);

        // Streaming: iVALID and iRES_READY held high -> one result per LAT+6 cycles.
        bus.iVALID = 1'b1; bus.iDATA = 8'd2; bus.iMODE = 1'b1; bus.iRES_READY = 1'b1;
        t = 0;
        while (!bus.oRES_VALID && t < 100) begin step(); t++; end
        c0 = cyc;
        check("stream_data0", bus.oRES_DATA, 8);
        step();
        t = 0;
        while (!bus.oRES_VALID && t < 100) begin step(); t++; end
        c1 = cyc;
        bus.iVALID = 1'b0;
        check("stream_period", c1 - c0, LAT + 6);
        check("stream_data1", bus.oRES_DATA, 8);
        step();
        bus.iRES_READY = 1'b0;
        check("stream_end_ready", bus.oREADY, 1);

        // Randomized transactions against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] r0, r1, r2, r3;
            bit m;
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
            m  = 1'($urandom);
            run_txn(r0, r1, r2, r3, m, madd(int'(r0), int'(r1), int'(r2), int'(r3), m),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

`ifdef MULTADD_DRV_CHECK_EN
        check("pre_mismatch", mismatch, 0);
        inject = 17'd1;
        run_txn(8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 17'd43, 0, 1'b0);
        inject = 17'd0;
        check("mismatch_set", mismatch, 1);
        run_txn(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 17'd14, 0, 1'b0);
        check("mismatch_sticky", mismatch, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
